gb_ppu_lcd_timing: RTL
======================

# gb_ppu_lcd_timing

Parametrised LCD timing sequencer for the PPU. Generates the dot counter, LY, and the PPU mode sequence (OAM_SCAN → DRAW → HBLANK, then VBLANK lines). Produces edge-qualified VBLANK and STAT interrupt requests with STAT line blocking, which level-decoded interrupts do not provide. It sits between the PPU register file, which supplies LCDC enable, LYC and STAT select bits, and the pixel pipeline, which returns `draw_done`.

## Interface
- `DOTS_PER_LINE`, 456, clk_t cycles per scanline
- `LINES_PER_FRAME`, 154, total lines per frame; must be ≤ 256
- `VISIBLE_LINES`, 144, lines with modes 2/3/0; must be < `LINES_PER_FRAME`
- `OAM_SCAN_DOTS`, 80, mode 2 length in dots
- `MAX_DRAW_DOTS`, 289, mode 3 cap; `OAM_SCAN_DOTS + MAX_DRAW_DOTS` must be < `DOTS_PER_LINE`
- Derived: `DOT_W = $clog2(DOTS_PER_LINE)`
- `clk_t` in 1: dot clock, the single clock domain
- `reset` in 1: asynchronous, active-low reset (asserted when 0)
- `lcd_en` in 1: LCDC bit 7
- `lyc` in 8: LY compare value
- `stat_sel` in 4: interrupt source enables; [3] LYC, [2] mode 2, [1] mode 1, [0] mode 0
- `draw_done` in 1: pixel pipeline has finished the line; sampled only in DRAW
- `ppu_mode` out `ppu_mode_state_t`: HBLANK=0, VBLANK=1, OAM_SCAN=2, DRAW=3
- `ly` out 8: current line
- `dot` out DOT_W: dot index within the line
- `lyc_eq` out 1: `ly == lyc`, combinational from registered `ly`
- `line_start` out 1: high while `dot == 0` and `lcd_en`
- `irq_vblank` out 1: one-cycle request
- `irq_stat` out 1: one-cycle request
- `draw_timeout` out 1: one-cycle pulse when mode 3 is ended by the cap

## Operation
- Reset values: `ppu_mode`=HBLANK, `ly`=0, `dot`=0, `irq_vblank`=0, `irq_stat`=0, `draw_timeout`=0, internal `stat_line_q`=0.
- `lcd_en`=0: on every edge, synchronously force `dot`=0, `ly`=0, HBLANK, and `stat_line_q`=0. `irq_*`, `draw_timeout` and `line_start` are held at 0.
- The first cycle with `lcd_en`=1 is dot 0 of line 0, with mode OAM_SCAN.
- Counters:
  - `dot` increments every cycle and wraps from `DOTS_PER_LINE-1` to 0.
  - On that wrap `ly` increments, wrapping from `LINES_PER_FRAME-1` to 0.
- Per-line FSM for `ly < VISIBLE_LINES`:
  - OAM_SCAN for dots 0..`OAM_SCAN_DOTS-1`.
  - DRAW from dot `OAM_SCAN_DOTS`.
  - DRAW → HBLANK on the edge where `draw_done`=1, or on the edge leaving dot `OAM_SCAN_DOTS+MAX_DRAW_DOTS-1` (this also pulses `draw_timeout`). If both occur on the same edge, `draw_done` wins and there is no timeout.
  - HBLANK until the line wraps.
- For `ly ≥ VISIBLE_LINES`: VBLANK for the entire line. `draw_done` is ignored outside DRAW.
- Next-line mode: OAM_SCAN if the new `ly < VISIBLE_LINES`, else VBLANK.
- `irq_vblank`: registered; high exactly in the first cycle of VBLANK (`ly`=`VISIBLE_LINES`, `dot`=0).
- STAT line: `stat_line = (lyc_eq & stat_sel[3]) | (mode==OAM_SCAN & stat_sel[2]) | (mode==VBLANK & stat_sel[1]) | (mode==HBLANK & stat_sel[0])`.
  - `stat_line_q <= stat_line` every cycle.
  - `irq_stat = stat_line & ~stat_line_q & lcd_en`.
  - A source rising while the line is already high produces no request (blocking).
  - A `stat_sel` or `lyc` change that raises the line produces a request.

## Timing
- All state is registered on `posedge clk_t`. `lyc_eq`, `line_start` and `irq_stat` are combinational from registers and the `lyc`/`stat_sel` inputs.
- Mode and counters take effect in the cycle after the deciding edge. `draw_done` asserted in the first DRAW cycle gives a one-dot mode 3.
- Line length is fixed at `DOTS_PER_LINE` regardless of when mode 3 ends. Frame length is `DOTS_PER_LINE*LINES_PER_FRAME` cycles (70224 by default).
- Reset asserted mid-frame: outputs take their reset values immediately. After release, the first edge behaves per `lcd_en`.
- `lcd_en` falling mid-line: the next edge gives `ly`=0, `dot`=0, HBLANK. No pending interrupt survives.

## Test plan
- Defaults, `lcd_en`=1, `draw_done` pulsed at dot 252 → OAM_SCAN for dots 0–79, DRAW for 80–252, HBLANK for 253–455; `ly` increments after 456 cycles; `draw_timeout` stays 0.
- `draw_done` held 0 → DRAW ends at dot 368; `draw_timeout` pulses once on the transition; HBLANK starts at dot 369 on every visible line.
- Two full frames → `irq_vblank` pulses exactly once per 70224 cycles at `ly`=144, `dot`=0; `ly` runs 153→0 and mode goes VBLANK→OAM_SCAN.
- `lyc`=10, `stat_sel`=4'b1000 → exactly one `irq_stat` per frame at `ly`=10, `dot`=0; `lyc_eq` is high for 456 cycles.
- `stat_sel`=4'b0011 → 144 `irq_stat` pulses per frame (one per HBLANK entry). Line 143's HBLANK→VBLANK transition produces no pulse (blocking).
- `lcd_en` dropped at `ly`=50, `dot`=200, then raised 10 cycles later → zeroed counters, HBLANK, and no IRQs while disabled; the first enabled cycle is OAM_SCAN, dot 0. A separate run asserts `reset` mid-DRAW and checks that all outputs are 0/HBLANK asynchronously.

Source files
------------

// File: rtl/gb_ppu_lcd_timing.sv
// LCD timing sequencer: dot/line counters, PPU mode sequence and
// edge-qualified VBLANK/STAT interrupt requests with STAT line blocking.
package gb_ppu_lcd_timing_pkg;
    typedef enum logic [1:0] {
        HBLANK   = 2'd0,
        VBLANK   = 2'd1,
        OAM_SCAN = 2'd2,
        DRAW     = 2'd3
    } ppu_mode_state_t;
endpackage

module gb_ppu_lcd_timing
    import gb_ppu_lcd_timing_pkg::*;
#(
    parameter int DOTS_PER_LINE   = 456,
    parameter int LINES_PER_FRAME = 154,
    parameter int VISIBLE_LINES   = 144,
    parameter int OAM_SCAN_DOTS   = 80,
    parameter int MAX_DRAW_DOTS   = 289,
    localparam int DOT_W          = $clog2(DOTS_PER_LINE)
) (
    input  logic             i_clk_t,
    input  logic             i_reset,
    input  logic             i_lcd_en,
    input  logic [7:0]       i_lyc,
    input  logic [3:0]       i_stat_sel,
    input  logic             i_draw_done,
    output ppu_mode_state_t  o_ppu_mode,
    output logic [7:0]       o_ly,
    output logic [DOT_W-1:0] o_dot,
    output logic             o_lyc_eq,
    output logic             o_line_start,
    output logic             o_irq_vblank,
    output logic             o_irq_stat,
    output logic             o_draw_timeout
);

    localparam logic [DOT_W-1:0] DOT_LAST      = DOT_W'(DOTS_PER_LINE - 1);
    localparam logic [DOT_W-1:0] DOT_OAM_LAST  = DOT_W'(OAM_SCAN_DOTS - 1);
    localparam logic [DOT_W-1:0] DOT_DRAW_LAST = DOT_W'(OAM_SCAN_DOTS + MAX_DRAW_DOTS - 1);
    localparam logic [7:0]       LY_LAST       = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0]       LY_VIS        = 8'(VISIBLE_LINES);

    ppu_mode_state_t  r_mode;
    logic [DOT_W-1:0] r_dot;
    logic [7:0]       r_ly;
    logic             r_idle;
    logic             r_stat_q;
    logic             r_irq_vblank;
    logic             r_draw_timeout;

    logic             w_en;
    ppu_mode_state_t  w_mode;
    ppu_mode_state_t  w_mode_nxt;
    logic             w_line_wrap;
    logic [DOT_W-1:0] w_dot_nxt;
    logic [7:0]       w_ly_nxt;
    logic             w_timeout_nxt;
    logic             w_stat_line;

    assign w_en = i_lcd_en & i_reset;

    // The idle (disabled) state presents as dot 0 of line 0 in OAM scan as
    // soon as the LCD is enabled, so the first enabled cycle needs no edge.
    assign w_mode = (r_idle && w_en) ? OAM_SCAN : r_mode;

    assign w_line_wrap = (r_dot == DOT_LAST);
    assign w_dot_nxt   = w_line_wrap ? '0 : r_dot + DOT_W'(1);
    assign w_ly_nxt    = !w_line_wrap ? r_ly :
                         (r_ly == LY_LAST) ? 8'd0 : r_ly + 8'd1;

    always_comb begin
        w_mode_nxt    = w_mode;
        w_timeout_nxt = 1'b0;
        case (w_mode)
            OAM_SCAN: begin
                if (r_dot == DOT_OAM_LAST) begin
                    w_mode_nxt = DRAW;
                end
            end
            DRAW: begin
                if (i_draw_done) begin
                    w_mode_nxt = HBLANK;
                end else if (r_dot == DOT_DRAW_LAST) begin
                    w_mode_nxt    = HBLANK;
                    w_timeout_nxt = 1'b1;
                end
            end
            HBLANK, VBLANK: begin
                if (w_line_wrap) begin
                    w_mode_nxt = (w_ly_nxt < LY_VIS) ? OAM_SCAN : VBLANK;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk_t or negedge i_reset) begin
        if (!i_reset) begin
            r_mode         <= HBLANK;
            r_dot          <= '0;
            r_ly           <= 8'd0;
            r_idle         <= 1'b1;
            r_stat_q       <= 1'b0;
            r_irq_vblank   <= 1'b0;
            r_draw_timeout <= 1'b0;
        end else if (!i_lcd_en) begin
            r_mode         <= HBLANK;
            r_dot          <= '0;
            r_ly           <= 8'd0;
            r_idle         <= 1'b1;
            r_stat_q       <= 1'b0;
            r_irq_vblank   <= 1'b0;
            r_draw_timeout <= 1'b0;
        end else begin
            r_mode         <= w_mode_nxt;
            r_dot          <= w_dot_nxt;
            r_ly           <= w_ly_nxt;
            r_idle         <= 1'b0;
            r_stat_q       <= w_stat_line;
            r_irq_vblank   <= w_line_wrap & (w_ly_nxt == LY_VIS);
            r_draw_timeout <= w_timeout_nxt;
        end
    end

    assign w_stat_line = (o_lyc_eq              & i_stat_sel[3])
                       | ((w_mode == OAM_SCAN)  & i_stat_sel[2])
                       | ((w_mode == VBLANK)    & i_stat_sel[1])
                       | ((w_mode == HBLANK)    & i_stat_sel[0]);

    assign o_ppu_mode     = w_mode;
    assign o_ly           = r_ly;
    assign o_dot          = r_dot;
    assign o_lyc_eq       = (r_ly == i_lyc);
    assign o_line_start   = w_en & (r_dot == '0);
    assign o_irq_vblank   = r_irq_vblank & w_en;
    assign o_irq_stat     = w_stat_line & ~r_stat_q & w_en;
    assign o_draw_timeout = r_draw_timeout & w_en;

endmodule
